nibble_serial_adder_ctrl: RTL and testbench

//  Sequencer that adds or subtracts wide operands on a single external full_adder_4bit.
//  It sits directly upstream of the adder and feeds it one nibble per cycle, LSB first.
//  It also consumes the adder's sum/c_out, chains the carry through a register, and

---
 rtl/nibble_serial_adder_ctrl_if.sv | 36 +++
 rtl/nibble_serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Bundle of the request/result handshake and the external 4-bit adder hookup.
// The sequencer uses the slave view; the environment (producer, consumer, adder) uses master.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         sub;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport slave (
    input  in_valid, op_a, op_b, carry_in, sub, out_ready, add_sum, add_cout,
    output in_ready, out_valid, result, carry_out, overflow, add_a, add_b, add_cin
  );

  modport master (
    output in_valid, op_a, op_b, carry_in, sub, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, result, carry_out, overflow, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced one nibble per cycle (LSB first) through an external
// 4-bit full adder, with the carry chained through a register between slices.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a request; adder inputs held at 0
//   S_RUN  | nibble idx_q on the adder; sum slice and carry captured each edge
//   S_DONE | result/carry_out/overflow valid until the consumer takes it
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic          carry_out_q;
  logic          overflow_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  always_comb begin
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state_q == S_RUN) begin
      bus.add_a   = nib_a;
      bus.add_b   = nib_b;
      bus.add_cin = carry_q;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1.
            a_q        <= bus.op_a;
            b_q        <= bus.op_b ^ {W{bus.sub}};
            carry_q    <= bus.sub | bus.carry_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[4*idx_q +: 4] <= bus.add_sum;
          carry_q                <= bus.add_cout;
          idx_q                  <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            // Top slice: add_sum[3] is the result sign bit.
            carry_out_q <= bus.add_cout;
            overflow_q  <= (a_q[W-1] == b_q[W-1]) && (bus.add_sum[3] != a_q[W-1]);
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: an arithmetic reference of each operation, checked
// every cycle against the DUT, plus directed literal cases and randomized traffic.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External 4-bit full adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: cyc = -1 idle, 0..N-1 nibble on the adder, N result pending.
  int           cyc = -1;
  logic [W-1:0] m_a = '0, m_beff = '0;
  logic         m_cin0 = 1'b0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_co = 1'b0, m_ov = 1'b0, p_co = 1'b0, p_ov = 1'b0;

  always @(posedge clk) begin
    logic [W:0] full;
    longint     sa, sb, tot, lim;
    if (rst) begin
      cyc   = -1;
      m_res = '0;
      m_co  = 1'b0;
      m_ov  = 1'b0;
    end else if (cyc < 0) begin
      if (bus.in_valid) begin
        m_a    = bus.op_a;
        m_beff = bus.sub ? ~bus.op_b : bus.op_b;
        m_cin0 = bus.sub ? 1'b1 : bus.carry_in;
        full   = {1'b0, m_a} + {1'b0, m_beff} + (W+1)'(m_cin0);
        p_res  = full[W-1:0];
        p_co   = full[W];
        sa     = longint'($signed(bus.op_a));
        sb     = longint'($signed(bus.op_b));
        tot    = bus.sub ? (sa - sb) : (sa + sb + longint'(bus.carry_in));
        lim    = longint'(1) << (W - 1);
        p_ov   = (tot >= lim) || (tot < -lim);
        cyc    = 0;
      end
    end else if (cyc < N) begin
      cyc++;
      if (cyc == N) begin
        m_res = p_res;
        m_co  = p_co;
        m_ov  = p_ov;
      end
    end else if (bus.out_ready) begin
      cyc = -1;
    end
  end

  always @(negedge clk) begin
    longint mask, lowsum;
    logic [3:0] e_a, e_b;
    logic       e_c;
    chk("in_ready", bus.in_ready, cyc < 0);
    chk("out_valid", bus.out_valid, cyc == N);
    if (cyc < 0 || cyc == N) begin
      chk("result", bus.result, m_res);
      chk("carry_out", bus.carry_out, m_co);
      chk("overflow", bus.overflow, m_ov);
    end
    e_a = 4'h0; e_b = 4'h0; e_c = 1'b0;
    if (cyc >= 0 && cyc < N) begin
      e_a = m_a[4*cyc +: 4];
      e_b = m_beff[4*cyc +: 4];
      if (cyc == 0) e_c = m_cin0;
      else begin
        mask   = (longint'(1) << (4*cyc)) - 1;
        lowsum = (longint'(m_a) & mask) + (longint'(m_beff) & mask) + longint'(m_cin0);
        e_c    = ((lowsum >> (4*cyc)) & 1) != 0;
      end
    end
    chk("add_a", bus.add_a, e_a);
    chk("add_b", bus.add_b, e_b);
    chk("add_cin", bus.add_cin, e_c);
  end

  logic [3:0] tr_a [N];
  logic [3:0] tr_b [N];
  logic       tr_c [N];

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic s, input int hold, input bit noise,
                       output logic [W-1:0] r, output logic co, output logic ov);
    int lat = 0;
    wait_idle();
    bus.op_a = a; bus.op_b = b; bus.carry_in = cin; bus.sub = s;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (lat < N) begin
        tr_a[lat] = bus.add_a; tr_b[lat] = bus.add_b; tr_c[lat] = bus.add_cin;
      end
      if (noise) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.op_a      = W'($urandom);
      end
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(N));
    r = bus.result; co = bus.carry_out; ov = bus.overflow;
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.op_a      = W'($urandom);
      bus.op_b      = W'($urandom);
      @(negedge clk);
      chk("done_in_ready", bus.in_ready, 1'b0);
      chk("done_result_hold", bus.result, r);
      chk("done_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic         co, ov;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    logic         co, ov;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.carry_in = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0, r, co, ov);
    chk("t1_result", r, 16'h2233); chk("t1_co", co, 0); chk("t1_ov", ov, 0);
    chk("t1_model", p_res, 16'h2233);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0, r, co, ov);
    chk("t2a_result", r, 16'h0000); chk("t2a_co", co, 1); chk("t2a_ov", ov, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0, r, co, ov);
    chk("t2b_result", r, 16'h8000); chk("t2b_ov", ov, 1); chk("t2b_model_ov", p_ov, 1);

    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0, r, co, ov);
    chk("t3a_result", r, 16'hFFFE); chk("t3a_co", co, 0); chk("t3a_ov", ov, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0, r, co, ov);
    chk("t3b_result", r, 16'h7FFF); chk("t3b_co", co, 1); chk("t3b_ov", ov, 1);
    chk("t3b_model", p_res, 16'h7FFF);

    do_op(16'h0102, 16'h0304, 1'b1, 1'b0, 3, 0, r, co, ov);
    chk("t4_result", r, 16'h0407);

    // Reset while nibble 2 is on the adder.
    wait_idle();
    bus.op_a = 16'hABCD; bus.op_b = 16'h1111; bus.carry_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_add_a_idx2", bus.add_a, 4'hB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", bus.in_ready, 1); chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_result", bus.result, 0); chk("t5_add_a", bus.add_a, 0);
    chk("t5_add_b", bus.add_b, 0); chk("t5_add_cin", bus.add_cin, 0);

    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, 0, r, co, ov);
    chk("t6_a0", tr_a[0], 4'hD); chk("t6_a1", tr_a[1], 4'hC);
    chk("t6_a2", tr_a[2], 4'hB); chk("t6_a3", tr_a[3], 4'hA);
    for (int i = 0; i < N; i++) begin
      chk("t6_b", tr_b[i], 4'h1);
      chk("t6_cin", tr_c[i], 1'b0);
    end
    chk("t6_result", r, 16'hBCDE);

    for (int k = 0; k < 40; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 1, r, co, ov);
    end
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 0, r, co, ov);
    chk("edge_min_add", r, 16'h0000); chk("edge_min_ov", ov, 1); chk("edge_min_co", co, 1);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0, 0, r, co, ov);
    chk("edge_zero_sub_co", co, 1); chk("edge_zero_sub_res", r, 16'h0000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
